// File: rtl/mem_stage_lsu.sv
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM pipeline stage with load extraction and variable-latency
//            data SRAM handshake (stall request plus one-entry read buffer).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int RF_AW     = 5,
    parameter int STALL_W   = 6,
    parameter int STALL_IDX = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               ex_valid,
    input  logic [PC_W-1:0]    ex_pc,
    input  logic               ex_mem_re,
    input  logic [2:0]         ex_ld_op,
    input  logic [1:0]         ex_addr_lo,
    input  logic               ex_rf_we,
    input  logic [RF_AW-1:0]   ex_rf_waddr,
    input  logic [XLEN-1:0]    ex_result,
    input  logic [XLEN-1:0]    data_sram_rdata,
    input  logic               data_ok,
    output logic               mem_stallreq,
    output logic               wb_valid,
    output logic [PC_W-1:0]    wb_pc,
    output logic               wb_rf_we,
    output logic [RF_AW-1:0]   wb_rf_waddr,
    output logic [XLEN-1:0]    wb_rf_wdata,
    output logic               fwd_rf_we,
    output logic [RF_AW-1:0]   fwd_rf_waddr,
    output logic [XLEN-1:0]    fwd_rf_wdata,
    output logic               fwd_load_pending
);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_WAIT   = 1'b1;
    localparam logic [2:0] c_OP_LB  = 3'd1;
    localparam logic [2:0] c_OP_LBU = 3'd2;
    localparam logic [2:0] c_OP_LH  = 3'd3;
    localparam logic [2:0] c_OP_LHU = 3'd4;

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic              r_mem_re;
    logic [2:0]        r_ld_op;
    logic [1:0]        r_addr_lo;
    logic              r_rf_we;
    logic [RF_AW-1:0]  r_rf_waddr;
    logic [XLEN-1:0]   r_result;

    logic [0:0]        r_state;
    logic              r_buf_valid;
    logic [XLEN-1:0]   r_rdata_buf;

    logic              w_hold;
    logic              w_next_hold;
    logic              w_reload;
    logic              w_is_load;
    logic              w_stallreq;
    logic [XLEN-1:0]   w_raw;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_rf_wdata;
    logic              w_unused_stall;

    assign w_hold         = stall[STALL_IDX];
    assign w_next_hold    = stall[STALL_IDX+1];
    // Register takes new content on advance (stage free) or bubble (next stage free).
    assign w_reload       = ~w_hold | ~w_next_hold;
    assign w_unused_stall = ^stall;

    always_ff @(posedge clk) begin
        if (rst || (w_hold && !w_next_hold)) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_mem_re   <= 1'b0;
            r_ld_op    <= 3'd0;
            r_addr_lo  <= 2'd0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_result   <= '0;
        end else if (!w_hold) begin
            r_valid    <= ex_valid;
            r_pc       <= ex_pc;
            r_mem_re   <= ex_mem_re;
            r_ld_op    <= ex_ld_op;
            r_addr_lo  <= ex_addr_lo;
            r_rf_we    <= ex_rf_we;
            r_rf_waddr <= ex_rf_waddr;
            r_result   <= ex_result;
        end
    end

    assign w_is_load  = r_valid & r_mem_re;
    assign w_stallreq = ((r_state == c_WAIT) & ~data_ok)
                      | ((r_state == c_IDLE) & w_is_load & ~data_ok & ~r_buf_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_is_load && !data_ok && !r_buf_valid) r_state <= c_WAIT;
                c_WAIT:  if (data_ok) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Data arriving while the stage cannot move on is kept until it does.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_rdata_buf <= '0;
        end else if (w_reload) begin
            r_buf_valid <= 1'b0;
        end else if (w_is_load && data_ok && !r_buf_valid) begin
            r_buf_valid <= 1'b1;
            r_rdata_buf <= data_sram_rdata;
        end
    end

    assign w_raw = r_buf_valid ? r_rdata_buf : data_sram_rdata;

    always_comb begin
        w_byte = w_raw[7:0];
        case (r_addr_lo)
            2'd1:    w_byte = w_raw[15:8];
            2'd2:    w_byte = w_raw[23:16];
            2'd3:    w_byte = w_raw[31:24];
            default: w_byte = w_raw[7:0];
        endcase
        w_half = r_addr_lo[1] ? w_raw[31:16] : w_raw[15:0];
        case (r_ld_op)
            c_OP_LB:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_OP_LBU: w_load = {{(XLEN-8){1'b0}}, w_byte};
            c_OP_LH:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            c_OP_LHU: w_load = {{(XLEN-16){1'b0}}, w_half};
            default:  w_load = w_raw;
        endcase
    end

    assign w_rf_wdata       = r_mem_re ? w_load : r_result;

    assign mem_stallreq     = w_stallreq;
    assign wb_valid         = r_valid & ~w_stallreq;
    assign wb_pc            = r_pc;
    assign wb_rf_we         = r_rf_we & r_valid & ~w_stallreq;
    assign wb_rf_waddr      = r_rf_waddr;
    assign wb_rf_wdata      = w_rf_wdata;
    assign fwd_rf_we        = r_valid & r_rf_we;
    assign fwd_rf_waddr     = r_rf_waddr;
    assign fwd_rf_wdata     = w_rf_wdata;
    assign fwd_load_pending = w_is_load & w_stallreq;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Directed self-checking bench for mem_stage_lsu with a
//            cycle-level reference model of the stage contents.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  base_stall;
    logic [5:0]  stall;
    logic        ex_valid, ex_mem_re, ex_rf_we;
    logic [31:0] ex_pc, ex_result;
    logic [2:0]  ex_ld_op;
    logic [1:0]  ex_addr_lo;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] data_sram_rdata;
    logic        data_ok;
    logic        mem_stallreq, wb_valid, wb_rf_we, fwd_rf_we, fwd_load_pending;
    logic [31:0] wb_pc, wb_rf_wdata, fwd_rf_wdata;
    logic [4:0]  wb_rf_waddr, fwd_rf_waddr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // The bench plays the stall controller: a stall request freezes stages 0..4.
    assign stall = base_stall | (mem_stallreq ? 6'b011111 : 6'b000000);

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_mem_re(ex_mem_re),
        .ex_ld_op(ex_ld_op), .ex_addr_lo(ex_addr_lo), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
        .data_sram_rdata(data_sram_rdata), .data_ok(data_ok),
        .mem_stallreq(mem_stallreq), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
        .fwd_rf_we(fwd_rf_we), .fwd_rf_waddr(fwd_rf_waddr),
        .fwd_rf_wdata(fwd_rf_wdata), .fwd_load_pending(fwd_load_pending)
    );

    // Reference model: what instruction sits in MEM and whether its data is already in hand.
    logic        m_live = 1'b0;
    logic        m_valid, m_re, m_we, m_got;
    logic [31:0] m_pc, m_result, m_data;
    logic [2:0]  m_op;
    logic [1:0]  m_lo;
    logic [4:0]  m_waddr;
    logic        exp_pend;
    logic [31:0] exp_wdata;

    function automatic logic [31:0] model_ext(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] raw);
        logic [31:0] v;
        case (op)
            3'd1, 3'd2: begin
                v = (raw >> (8 * lo)) & 32'hFF;
                if (op == 3'd1 && v >= 32'd128) v = v | 32'hFFFFFF00;
            end
            3'd3, 3'd4: begin
                v = (raw >> (16 * lo[1])) & 32'hFFFF;
                if (op == 3'd3 && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            default: v = raw;
        endcase
        return v;
    endfunction

    always_comb begin
        exp_pend  = m_valid && m_re && !m_got && !data_ok;
        exp_wdata = m_re ? model_ext(m_op, m_lo, m_got ? m_data : data_sram_rdata) : m_result;
    end

    always @(posedge clk) begin
        logic [5:0] s;
        s = base_stall | (exp_pend ? 6'b011111 : 6'b000000);
        if (rst) begin
            {m_valid, m_re, m_we, m_got} = 4'b0;
            m_pc = 0; m_result = 0; m_data = 0; m_op = 0; m_lo = 0; m_waddr = 0;
            m_live = 1'b1;
        end else if (!s[3]) begin
            m_valid = ex_valid; m_pc = ex_pc; m_re = ex_mem_re; m_op = ex_ld_op;
            m_lo = ex_addr_lo; m_we = ex_rf_we; m_waddr = ex_rf_waddr; m_result = ex_result;
            m_got = 1'b0;
        end else if (!s[4]) begin
            {m_valid, m_re, m_we, m_got} = 4'b0;
            m_pc = 0; m_result = 0; m_op = 0; m_lo = 0; m_waddr = 0;
        end else if (m_valid && m_re && !m_got && data_ok) begin
            m_got = 1'b1;
            m_data = data_sram_rdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_stallreq", {31'd0, mem_stallreq}, {31'd0, exp_pend});
            chk("m_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid && !exp_pend});
            chk("m_wb_rf_we", {31'd0, wb_rf_we}, {31'd0, m_valid && m_we && !exp_pend});
            chk("m_wb_pc", wb_pc, m_pc);
            chk("m_wb_waddr", {27'd0, wb_rf_waddr}, {27'd0, m_waddr});
            chk("m_wb_wdata", wb_rf_wdata, exp_wdata);
            chk("m_fwd_we", {31'd0, fwd_rf_we}, {31'd0, m_valid && m_we});
            chk("m_fwd_waddr", {27'd0, fwd_rf_waddr}, {27'd0, m_waddr});
            chk("m_fwd_pending", {31'd0, fwd_load_pending}, {31'd0, exp_pend});
            if (!exp_pend) chk("m_fwd_wdata", fwd_rf_wdata, exp_wdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic re,
                          input logic [2:0] op, input logic [1:0] lo, input logic we,
                          input logic [4:0] wa, input logic [31:0] res);
        ex_valid = v; ex_pc = pc; ex_mem_re = re; ex_ld_op = op; ex_addr_lo = lo;
        ex_rf_we = we; ex_rf_waddr = wa; ex_result = res;
    endtask

    logic [2:0]  t_op [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [1:0]  t_lo [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
    logic [31:0] t_exp[4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};

    initial begin
        rst = 1'b1; base_stall = 6'b0; data_ok = 1'b0; data_sram_rdata = 32'h0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        peek();
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        chk("rst_stallreq", {31'd0, mem_stallreq}, 32'd0);

        // ALU instruction passes straight through
        rst = 1'b0;
        set_ex(1, 32'h100, 0, 0, 0, 1, 5'd5, 32'h1234);
        cyc();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        peek();
        chk("alu_we", {31'd0, wb_rf_we}, 32'd1);
        chk("alu_waddr", {27'd0, wb_rf_waddr}, 32'd5);
        chk("alu_wdata", wb_rf_wdata, 32'h00001234);
        chk("alu_stallreq", {31'd0, mem_stallreq}, 32'd0);

        // Byte/half loads with same-cycle data
        for (int i = 0; i < 4; i++) begin
            cyc();
            set_ex(1, 32'h200 + 32'(i * 4), 1, t_op[i], t_lo[i], 1, 5'd6, 32'h0);
            cyc();
            set_ex(0, 0, 0, 0, 0, 0, 0, 0);
            data_ok = 1'b1; data_sram_rdata = 32'h80FF7F01;
            peek();
            chk("ld_ext", wb_rf_wdata, t_exp[i]);
            cyc();
            data_ok = 1'b0;
        end

        // LW with data three cycles late
        set_ex(1, 32'h300, 1, 3'd0, 2'd0, 1, 5'd7, 32'h0);
        cyc();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        data_sram_rdata = 32'h0BADF00D;
        for (int i = 0; i < 3; i++) begin
            peek();
            chk("wait_stallreq", {31'd0, mem_stallreq}, 32'd1);
            chk("wait_pending", {31'd0, fwd_load_pending}, 32'd1);
            chk("wait_wb_valid", {31'd0, wb_valid}, 32'd0);
            cyc();
        end
        data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF;
        peek();
        chk("late_wdata", wb_rf_wdata, 32'hDEADBEEF);
        chk("late_we", {31'd0, wb_rf_we}, 32'd1);
        chk("late_stallreq", {31'd0, mem_stallreq}, 32'd0);
        cyc();
        data_ok = 1'b0;

        // LW data arrives while downstream holds the stage
        set_ex(1, 32'h400, 1, 3'd0, 2'd0, 1, 5'd8, 32'h0);
        cyc();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        base_stall = 6'b011111; data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D;
        peek();
        chk("buf_first", wb_rf_wdata, 32'hCAFEF00D);
        for (int i = 0; i < 2; i++) begin
            cyc();
            data_ok = 1'b0; data_sram_rdata = 32'h11111111 * 32'(i + 1);
            peek();
            chk("buf_hold", wb_rf_wdata, 32'hCAFEF00D);
            chk("buf_stallreq", {31'd0, mem_stallreq}, 32'd0);
        end
        cyc();
        base_stall = 6'b0;
        set_ex(1, 32'h404, 1, 3'd0, 2'd0, 1, 5'd9, 32'h0);
        peek();
        chk("buf_release", wb_rf_wdata, 32'hCAFEF00D);
        cyc();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        peek();
        chk("buf_cleared", {31'd0, mem_stallreq}, 32'd1);
        cyc();
        data_ok = 1'b1; data_sram_rdata = 32'h00C0FFEE;
        cyc();
        data_ok = 1'b0;

        // Bubble then hold
        set_ex(1, 32'h500, 0, 0, 0, 1, 5'd10, 32'hAAAA);
        cyc();
        base_stall = 6'b001000;
        set_ex(1, 32'h504, 0, 0, 0, 1, 5'd11, 32'hBBBB);
        cyc();
        peek();
        chk("bub_valid", {31'd0, wb_valid}, 32'd0);
        chk("bub_pc", wb_pc, 32'd0);
        chk("bub_wdata", wb_rf_wdata, 32'd0);
        base_stall = 6'b0;
        cyc();
        base_stall = 6'b011000;
        set_ex(1, 32'h508, 0, 0, 0, 1, 5'd12, 32'hCCCC);
        cyc();
        peek();
        chk("hold_pc", wb_pc, 32'h504);
        chk("hold_wdata", wb_rf_wdata, 32'hBBBB);
        base_stall = 6'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // Reset in the middle of a wait
        set_ex(1, 32'h600, 1, 3'd0, 2'd0, 1, 5'd13, 32'h0);
        cyc();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0);
        peek();
        chk("rw_stallreq", {31'd0, mem_stallreq}, 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; data_ok = 1'b1; data_sram_rdata = 32'h55555555;
        peek();
        chk("rw_post_stallreq", {31'd0, mem_stallreq}, 32'd0);
        chk("rw_post_valid", {31'd0, wb_valid}, 32'd0);
        chk("rw_post_wdata", wb_rf_wdata, 32'd0);
        chk("rw_post_fwd_we", {31'd0, fwd_rf_we}, 32'd0);
        cyc();
        data_ok = 1'b0;
        peek();
        chk("rw_late_ignored", {31'd0, wb_valid}, 32'd0);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
